// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared state encoding and helpers for the instruction fetch front end
package instr_fetch_pkg;

   typedef enum logic {
      IF_STATE_RUN   = 1'b0,
      IF_STATE_FAULT = 1'b1
   } if_state_e;

   localparam logic [31:0] INSTR_ALIGN_MASK = 32'h0000_0003;

   function automatic logic [31:0] endian_swp_32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush and occupancy count
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic [WIDTH-1:0] head_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign do_push = push_i && (count_q != CW'(DEPTH));
   assign do_pop  = pop_i && (count_q != '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch front end: issues word reads, tags responses, buffers {pc, instr}
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          DEPTH      = 2,
   parameter bit          SWAP_BYTES = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [6:0]  if_opcode,
   input  logic        dec_ready,
   output logic        fault
);

   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int TW  = $clog2(2 * DEPTH) + 1;
   localparam int TWP = TW + 1;

   if_state_e   state_q;
   logic [31:0] pc_q;
   logic [TW-1:0] drop_q;
   logic        fault_q;

   logic [TW-1:0] tag_count;
   logic [31:0]   tag_head;
   logic [CW-1:0] buf_count;
   logic [63:0]   buf_head;
   logic [TWP-1:0] credit;
   logic          run;
   logic          ack_ok;
   logic          buf_push;
   logic [31:0]   resp_data;

   assign run    = (state_q == IF_STATE_RUN);
   // The tag FIFO occupancy is the outstanding-request count.
   assign ack_ok = imem_ack && (tag_count != '0);
   assign credit = {1'b0, tag_count} - {1'b0, drop_q} + TWP'(buf_count);

   // Stale requests still hold tags, so the tag FIFO is sized 2*DEPTH to absorb them.
   assign imem_req  = run && !rst && !redirect && (credit < TWP'(DEPTH))
                      && (tag_count < TW'(2 * DEPTH));
   assign imem_addr = pc_q;

   assign resp_data = SWAP_BYTES ? endian_swp_32(imem_rdata) : imem_rdata;
   assign buf_push  = ack_ok && run && !redirect && (drop_q == '0);

   assign if_valid  = run && (buf_count != '0);
   assign if_instr  = buf_head[31:0];
   assign if_pc     = buf_head[63:32];
   assign if_opcode = if_instr[6:0];
   assign fault     = fault_q;

   fetch_fifo #(.WIDTH(32), .DEPTH(2 * DEPTH)) u_tag_fifo (
      .clk_i       (clk),
      .rst_i       (rst),
      .push_i      (imem_req),
      .push_data_i (pc_q),
      .pop_i       (ack_ok),
      .flush_i     (1'b0),
      .head_o      (tag_head),
      .count_o     (tag_count)
   );

   fetch_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_buf_fifo (
      .clk_i       (clk),
      .rst_i       (rst),
      .push_i      (buf_push),
      .push_data_i ({tag_head, resp_data}),
      .pop_i       (if_valid && dec_ready),
      .flush_i     (run && redirect),
      .head_o      (buf_head),
      .count_o     (buf_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IF_STATE_RUN;
         pc_q    <= RESET_PC;
         drop_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         case (state_q)
            IF_STATE_RUN: begin
               if (redirect) begin
                  pc_q   <= redirect_pc;
                  drop_q <= tag_count - TW'(ack_ok);
                  if ((redirect_pc & INSTR_ALIGN_MASK) != 32'h0) begin
                     state_q <= IF_STATE_FAULT;
                     fault_q <= 1'b1;
                  end
               end else begin
                  if (imem_req) pc_q <= pc_q + 32'd4;
                  if (ack_ok && (drop_q != '0)) drop_q <= drop_q - TW'(1);
               end
            end
            default: begin
               if (ack_ok && (drop_q != '0)) drop_q <= drop_q - TW'(1);
            end
         endcase
      end
   end

endmodule
